// File: rtl/stop_watch_param_pkg.sv
// Shared constants, types and helpers for the parameterised BCD stopwatch.
package stop_watch_param_pkg;

  localparam int NIB_W = 4;
  localparam logic [NIB_W-1:0] BCD_MAX = 4'd9;
  localparam int DVSR_DEFAULT = 5000000;

  typedef logic [NIB_W-1:0] bcd_t;

  // Any nibble outside the decimal range is treated as the largest digit.
  function automatic bcd_t bcd_clamp(input bcd_t nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/stop_watch_param_if.sv
// Control and display bundle between a stopwatch and whatever drives/observes it.
interface stop_watch_param_if
  import stop_watch_param_pkg::*;
#(
  parameter int NDIG = 3
);

  logic                  go;
  logic                  clr;
  logic                  up;
  logic                  load;
  logic [NIB_W*NDIG-1:0] load_val;
  logic                  lap;
  logic [NIB_W*NDIG-1:0] digits;
  logic                  frozen;
  logic                  lim;

  modport master (
    output go, clr, up, load, load_val, lap,
    input  digits, frozen, lim
  );

  modport slave (
    input  go, clr, up, load, load_val, lap,
    output digits, frozen, lim
  );

endinterface

// File: rtl/stop_watch_param_bcd_digit.sv
// One BCD up/down digit; carry/borrow flag that the next enable would roll it over.
module bcd_digit
  import stop_watch_param_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic load,
  input  bcd_t load_val,
  input  logic en,
  input  logic up,
  input  logic sat_hold,
  output bcd_t value,
  output logic carry,
  output logic borrow
);

  bcd_t value_d;
  bcd_t value_q;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (load) begin
      value_d = bcd_clamp(load_val);
    end else if (en && !sat_hold) begin
      if (up) begin
        value_d = (value_q == BCD_MAX) ? '0 : value_q + 4'd1;
      end else begin
        value_d = (value_q == '0) ? BCD_MAX : value_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value  = value_q;
  assign carry  = up && (value_q == BCD_MAX);
  assign borrow = !up && (value_q == '0);

endmodule

// File: rtl/stop_watch_param.sv
// Parameterised BCD stopwatch: prescaler, rippled digit chain, wrap/saturate limit and lap freeze.
module stop_watch_param
  import stop_watch_param_pkg::*;
#(
  parameter int NDIG = 3,
  parameter int DVSR = DVSR_DEFAULT,
  parameter int SAT  = 0
)
(
  input  logic              clk,
  input  logic              reset_n,
  stop_watch_param_if.slave bus
);

  localparam int            PW         = $clog2(DVSR);
  localparam int            CW         = NIB_W * NDIG;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DVSR - 1);
  localparam bit            SAT_EN     = (SAT != 0);

  logic [PW-1:0] presc_d;
  logic [PW-1:0] presc_q;
  logic          tick;

  logic [NDIG:0]   en_chain;
  logic [NDIG-1:0] carry;
  logic [NDIG-1:0] borrow;
  logic [CW-1:0]   count;
  logic            at_limit;
  logic            sat_hold;

  logic [CW-1:0] disp_d;
  logic [CW-1:0] disp_q;
  logic          frozen_d;
  logic          frozen_q;
  logic          lim_d;
  logic          lim_q;

  assign tick = bus.go && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    if (bus.clr || bus.load) begin
      presc_d = '0;
    end else if (bus.go) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  // A tick only reaches the digits when neither clr nor load overrides it.
  assign en_chain[0] = tick && !bus.clr && !bus.load;

  for (genvar i = 0; i < NDIG; i++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (bus.clr),
      .load     (bus.load),
      .load_val (bus.load_val[i*NIB_W +: NIB_W]),
      .en       (en_chain[i]),
      .up       (bus.up),
      .sat_hold (sat_hold),
      .value    (count[i*NIB_W +: NIB_W]),
      .carry    (carry[i]),
      .borrow   (borrow[i])
    );
    assign en_chain[i+1] = en_chain[i] && (carry[i] || borrow[i]);
  end

  // Enable surviving the whole chain means every digit is about to roll: the limit.
  assign at_limit = en_chain[NDIG];
  assign sat_hold = SAT_EN && at_limit;
  assign lim_d    = at_limit;

  always_comb begin
    disp_d   = disp_q;
    frozen_d = frozen_q;
    if (bus.clr) begin
      disp_d   = '0;
      frozen_d = 1'b0;
    end else if (bus.lap) begin
      if (!frozen_q) begin
        disp_d   = count;
        frozen_d = 1'b1;
      end else begin
        frozen_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q  <= '0;
      disp_q   <= '0;
      frozen_q <= 1'b0;
      lim_q    <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      disp_q   <= disp_d;
      frozen_q <= frozen_d;
      lim_q    <= lim_d;
    end
  end

  assign bus.digits = frozen_q ? disp_q : count;
  assign bus.frozen = frozen_q;
  assign bus.lim    = lim_q;

endmodule

// File: tb/tb_stop_watch_param.sv
// Bench for stop_watch_param: a wrapping and a saturating instance share stimulus,
// checked every cycle against an integer model plus hand-computed literals.
module tb_stop_watch_param;

  localparam int NDIG = 3;
  localparam int DVSR = 4;
  localparam int CW   = 4 * NDIG;
  localparam int MAXV = 999;

  typedef struct packed {
    int cnt;
    int pre;
    int disp;
    bit frz;
    bit lim;
  } model_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          go, clr, up, load, lap;
  logic [CW-1:0] load_val;
  bit            chk_en = 1'b0;

  int comparisons = 0;
  int failures    = 0;

  model_t m0 = '0;
  model_t m1 = '0;

  stop_watch_param_if #(.NDIG(NDIG)) if0 ();
  stop_watch_param_if #(.NDIG(NDIG)) if1 ();

  assign if0.go = go;
  assign if0.clr = clr;
  assign if0.up = up;
  assign if0.load = load;
  assign if0.load_val = load_val;
  assign if0.lap = lap;
  assign if1.go = go;
  assign if1.clr = clr;
  assign if1.up = up;
  assign if1.load = load;
  assign if1.load_val = load_val;
  assign if1.lap = lap;

  stop_watch_param #(.NDIG(NDIG), .DVSR(DVSR), .SAT(0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if0.slave)
  );

  stop_watch_param #(.NDIG(NDIG), .DVSR(DVSR), .SAT(1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if1.slave)
  );

  always #5 clk = ~clk;

  function automatic int sanitize(input logic [CW-1:0] v);
    int r;
    int w;
    int n;
    r = 0;
    w = 1;
    for (int i = 0; i < NDIG; i++) begin
      n = int'(v[i*4 +: 4]);
      if (n > 9) n = 9;
      r = r + n * w;
      w = w * 10;
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] to_bcd(input int v);
    logic [CW-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < NDIG; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal stopwatch behaviour: integer count modulo 10^NDIG.
  function automatic model_t model_next(input model_t cur, input bit sat, input bit go_i,
                                        input bit clr_i, input bit up_i, input bit load_i,
                                        input logic [CW-1:0] lv, input bit lap_i);
    model_t n;
    bit tk;
    n = cur;
    n.lim = 1'b0;
    tk = go_i && (cur.pre == DVSR - 1);
    if (clr_i) begin
      n.frz = 1'b0;
      n.disp = 0;
    end else if (lap_i) begin
      if (!cur.frz) begin
        n.disp = cur.cnt;
        n.frz = 1'b1;
      end else begin
        n.frz = 1'b0;
      end
    end
    if (clr_i) begin
      n.cnt = 0;
      n.pre = 0;
    end else if (load_i) begin
      n.cnt = sanitize(lv);
      n.pre = 0;
    end else begin
      if (go_i) n.pre = tk ? 0 : cur.pre + 1;
      if (tk) begin
        if (up_i) begin
          if (cur.cnt == MAXV) begin
            n.lim = 1'b1;
            n.cnt = sat ? MAXV : 0;
          end else begin
            n.cnt = cur.cnt + 1;
          end
        end else begin
          if (cur.cnt == 0) begin
            n.lim = 1'b1;
            n.cnt = sat ? 0 : MAXV;
          end else begin
            n.cnt = cur.cnt - 1;
          end
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= model_next(m0, 1'b0, go, clr, up, load, load_val, lap);
      m1 <= model_next(m1, 1'b1, go, clr, up, load, load_val, lap);
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    comparisons++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_output("model_digits_sat0", 32'(if0.digits), 32'(to_bcd(m0.frz ? m0.disp : m0.cnt)));
      check_output("model_frozen_sat0", 32'(if0.frozen), 32'(m0.frz));
      check_output("model_lim_sat0",    32'(if0.lim),    32'(m0.lim));
      check_output("model_digits_sat1", 32'(if1.digits), 32'(to_bcd(m1.frz ? m1.disp : m1.cnt)));
      check_output("model_frozen_sat1", 32'(if1.frozen), 32'(m1.frz));
      check_output("model_lim_sat1",    32'(if1.lim),    32'(m1.lim));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input bit go_i, input bit clr_i, input bit up_i,
                                input bit load_i, input logic [CW-1:0] lv, input int n);
    go = go_i;
    clr = clr_i;
    up = up_i;
    load = load_i;
    load_val = lv;
    step(n);
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    step(1);
    lap = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    failures++;
    $display("End of test - %0d assertions evaluated, %0d failures", comparisons, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    go = 1'b0; clr = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; lap = 1'b0;
    #12 reset_n = 1'b1;
    chk_en = 1'b1;
    step(1);
    check_output("reset_digits", 32'(if0.digits), 32'h000);
    check_output("reset_frozen", 32'(if0.frozen), 32'h0);

    $display("[TB] count up 40 enabled cycles");
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 40);
    check_output("up40_sat0", 32'(if0.digits), 32'h010);
    check_output("up40_sat1", 32'(if1.digits), 32'h010);

    $display("[TB] wrap and saturate at 999");
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 12'h998, 1);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 4);
    check_output("to999_sat0", 32'(if0.digits), 32'h999);
    step(4);
    check_output("wrap_digits", 32'(if0.digits), 32'h000);
    check_output("wrap_lim", 32'(if0.lim), 32'h1);
    check_output("sat_digits", 32'(if1.digits), 32'h999);
    check_output("sat_lim", 32'(if1.lim), 32'h1);
    step(1);
    check_output("lim_one_cycle", 32'(if0.lim), 32'h0);
    step(3);
    check_output("sat_lim_again", 32'(if1.lim), 32'h1);
    check_output("after_wrap_sat0", 32'(if0.digits), 32'h001);

    $display("[TB] count down and underflow");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 12'h100, 1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 4);
    check_output("down_099", 32'(if0.digits), 32'h099);
    step(4);
    check_output("down_098", 32'(if1.digits), 32'h098);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 4);
    check_output("underflow_sat0", 32'(if0.digits), 32'h999);
    check_output("underflow_lim0", 32'(if0.lim), 32'h1);
    check_output("underflow_sat1", 32'(if1.digits), 32'h000);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 12'hA3F, 1);
    check_output("load_non_bcd", 32'(if0.digits), 32'h939);

    $display("[TB] lap freeze");
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 12'h005, 1);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 0);
    pulse_lap();
    check_output("lap_frozen", 32'(if0.frozen), 32'h1);
    step(11);
    check_output("lap_held", 32'(if0.digits), 32'h005);
    pulse_lap();
    check_output("lap_release_digits", 32'(if0.digits), 32'h008);
    check_output("lap_release_frozen", 32'(if0.frozen), 32'h0);

    $display("[TB] clr priority");
    go = 1'b0;
    pulse_lap();
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 2);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 12'h555, 1);
    check_output("clr_load_tick_digits", 32'(if0.digits), 32'h000);
    check_output("clr_load_tick_frozen", 32'(if0.frozen), 32'h0);
    check_output("clr_load_tick_lim", 32'(if0.lim), 32'h0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 0);
    pulse_lap();
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1);
    check_output("clr_unfreeze", 32'(if0.frozen), 32'h0);
    lap = 1'b1;
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1);
    lap = 1'b0;
    check_output("clr_ignores_lap", 32'(if0.frozen), 32'h0);

    $display("[TB] asynchronous reset mid-count");
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 6);
    check_output("pre_reset_count", 32'(if0.digits), 32'h001);
    #1 reset_n = 1'b0;
    #1;
    check_output("async_reset_digits", 32'(if0.digits), 32'h000);
    check_output("async_reset_lim", 32'(if1.lim), 32'h0);
    #3 reset_n = 1'b1;
    step(3);
    check_output("post_reset_no_tick", 32'(if0.digits), 32'h000);
    step(1);
    check_output("post_reset_first_tick", 32'(if0.digits), 32'h001);
    check_output("post_reset_lim", 32'(if0.lim), 32'h0);

    go = 1'b0;
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", comparisons, failures);
    $finish;
  end

endmodule
